// File: rtl/glyph_pkg.sv
// glyph_pkg: shared glyph constants and 16x16 row generator; operator glyphs for codes 10-13 only when GLYPH_FETCH_OPS_EN is defined
package glyph_pkg;
  localparam int CODE_W = 4;
  localparam int ROW_W = 4;
  localparam logic [CODE_W-1:0] OP_ADD = 4'd10;
  localparam logic [CODE_W-1:0] OP_SUB = 4'd11;
  localparam logic [CODE_W-1:0] OP_MUL = 4'd12;
  localparam logic [CODE_W-1:0] OP_DIV = 4'd13;
  localparam logic [15:0] BAR = 16'h1FF8;
  localparam logic [15:0] VL = 16'h1800;
  localparam logic [15:0] VR = 16'h001F;
  localparam logic [15:0] STEM = 16'h0180;
  // seven-segment masks {g,f,e,d,c,b,a} for digits 0-9; codes 10-15 have no segments
  localparam logic [15:0][6:0] SEG = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  // digits: row 0 top bar, rows 1-6 upper verticals, row 6 middle bar, rows 7-11 lower verticals, row 12 bottom bar
  function automatic logic [15:0] glyph_row16(input logic [CODE_W-1:0] c, input logic [ROW_W-1:0] r);
    logic [6:0] s;
    logic [15:0] o;
`ifdef GLYPH_FETCH_OPS_EN
    logic [3:0] i;
    logic [15:0] fwd, bwd;
`endif
    s = SEG[c];
    o = '0;
    o |= (r == 4'd0 && s[0]) ? BAR : '0;
    o |= (r >= 4'd1 && r <= 4'd6) ? (({16{s[5]}} & VL) | ({16{s[1]}} & VR)) : '0;
    o |= (r == 4'd6 && s[6]) ? BAR : '0;
    o |= (r >= 4'd7 && r <= 4'd11) ? (({16{s[4]}} & VL) | ({16{s[2]}} & VR)) : '0;
    o |= (r == 4'd12 && s[3]) ? BAR : '0;
`ifdef GLYPH_FETCH_OPS_EN
    i = r - 4'd2;
    fwd = (r >= 4'd2 && r <= 4'd11) ? (16'h0008 << i) : '0;
    bwd = (r >= 4'd2 && r <= 4'd11) ? (16'h1000 >> i) : '0;
    o |= (c == OP_ADD) ? (((r >= 4'd3 && r <= 4'd11) ? STEM : '0) | ((r == 4'd7) ? BAR : '0)) : '0;
    o |= (c == OP_SUB && r == 4'd7) ? BAR : '0;
    o |= (c == OP_MUL) ? (fwd | bwd) : '0;
    o |= (c == OP_DIV) ? fwd : '0;
`endif
    return o;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts at the pointer, pointer moves past the winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt, idx;
  // scan from the highest offset down so the lowest offset from the pointer wins
  always_comb begin
    grant = '0;
    nxt = ptr;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        nxt = PW'((int'(idx) + 1) % N);
      end
    end
  end
  // pointer holds when nothing requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else ptr <= nxt;
  end
endmodule

// File: rtl/glyph_fetch_rr.sv
// glyph_fetch_rr: multi-channel glyph row fetch, round-robin shared table port, 2-stage pipeline; GLYPH_FETCH_OPS_EN adds operator glyphs
module glyph_fetch_rr import glyph_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int GLYPH_W = 16,
  parameter int GLYPH_H = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           req,
  input  logic [NUM_CH*CODE_W-1:0]    code,
  input  logic [NUM_CH*ROW_W-1:0]     row,
  output logic [NUM_CH-1:0]           ack,
  output logic [NUM_CH-1:0]           valid,
  output logic [NUM_CH*GLYPH_W-1:0]   data
);
  logic [NUM_CH-1:0] gnt;
  logic [CODE_W-1:0] code_sel, s1_code;
  logic [ROW_W-1:0] row_sel, s1_row;
  logic [15:0] rd16;
  logic [GLYPH_W-1:0] rd;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (gnt)
  );

  // one-hot grant selects the winner's code and row
  always_comb begin
    code_sel = '0;
    row_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      code_sel |= gnt[k] ? code[k*CODE_W +: CODE_W] : '0;
      row_sel |= gnt[k] ? row[k*ROW_W +: ROW_W] : '0;
    end
  end

  // stage 1: capture the winner's request; the registered grant is the ack pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= '0;
      s1_code <= '0;
      s1_row <= '0;
    end else begin
      ack <= gnt;
      s1_code <= code_sel;
      s1_row <= row_sel;
    end
  end

  assign rd16 = ({1'b0, s1_row} < 5'(GLYPH_H)) ? glyph_row16(s1_code, s1_row) : '0;
  assign rd = rd16[15 -: GLYPH_W];

  // stage 2: load only the acked channel's slice; other slices hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      data <= '0;
    end else begin
      valid <= ack;
      for (int k = 0; k < NUM_CH; k++)
        if (ack[k]) data[k*GLYPH_W +: GLYPH_W] <= rd;
    end
  end
endmodule

// File: tb/tb_glyph_fetch_rr.sv
// tb_glyph_fetch_rr: directed checks of arbitration, pipeline timing, glyph rows, row range and reset
module tb_glyph_fetch_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0, ack, valid;
  logic [15:0] code = '0, row = '0;
  logic [63:0] data;
  logic [3:0] req12 = '0, ack12, valid12;
  logic [15:0] code12 = '0, row12 = '0;
  logic [63:0] data12;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  glyph_fetch_rr dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code), .row(row),
    .ack(ack), .valid(valid), .data(data)
  );

  glyph_fetch_rr #(.GLYPH_H(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .req(req12), .code(code12), .row(row12),
    .ack(ack12), .valid(valid12), .data(data12)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = '0;
    req12 = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (ack !== 4'h0) begin n_bad++; $display("FAIL reset_ack got %h want 0", ack); end
    n_cmp++; if (valid !== 4'h0) begin n_bad++; $display("FAIL reset_valid got %h want 0", valid); end
    n_cmp++; if (data !== 64'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", data); end
    n_cmp++; if (data12 !== 64'h0) begin n_bad++; $display("FAIL reset_data12 got %h want 0", data12); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    code[3:0] = 4'd9;
    row[3:0] = 4'd0;
    req = 4'b0001;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack got %b want 0001", ack); end
    n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL single_early_valid got %b want 0000", valid); end
    req = 4'b0000;
    tick();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_clear got %b want 0000", ack); end
    n_cmp++; if (valid !== 4'b0001) begin n_bad++; $display("FAIL single_valid got %b want 0001", valid); end
    n_cmp++; if (data[15:0] !== 16'h1FF8) begin n_bad++; $display("FAIL single_data got %h want 1ff8", data[15:0]); end
    tick();
    n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL single_valid_pulse got %b want 0000", valid); end
    n_cmp++; if (data[15:0] !== 16'h1FF8) begin n_bad++; $display("FAIL single_hold got %h want 1ff8", data[15:0]); end
  endtask

  localparam logic [3:0] TC [7] = '{4'd8, 4'd1, 4'd0, 4'd7, 4'd2, 4'd6, 4'd8};
  localparam logic [3:0] TR [7] = '{4'd3, 4'd9, 4'd12, 4'd12, 4'd6, 4'd9, 4'd14};
  localparam logic [15:0] TD [7] = '{16'h181F, 16'h001F, 16'h1FF8, 16'h0000, 16'h1FFF, 16'h181F, 16'h0000};

  task automatic test_digits;
    for (int i = 0; i < 7; i++) begin
      code[15:12] = TC[i];
      row[15:12] = TR[i];
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      n_cmp++; if (valid !== 4'b1000) begin n_bad++; $display("FAIL digit_valid[%0d] got %b want 1000", i, valid); end
      n_cmp++; if (data[63:48] !== TD[i]) begin n_bad++; $display("FAIL digit_row[%0d] code %0d row %0d got %h want %h", i, TC[i], TR[i], data[63:48], TD[i]); end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_a, prev;
    do_reset();
    code = {4'd3, 4'd2, 4'd1, 4'd0};
    row = '0;
    prev = '0;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_a = 4'b0001 << (i % 4);
      n_cmp++; if (ack !== exp_a) begin n_bad++; $display("FAIL rr_ack[%0d] got %b want %b", i, ack, exp_a); end
      n_cmp++; if (valid !== prev) begin n_bad++; $display("FAIL rr_valid[%0d] got %b want %b", i, valid, prev); end
      prev = exp_a;
    end
    req = 4'b0000;
    tick();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rr_ack_idle got %b want 0000", ack); end
    n_cmp++; if (valid !== 4'b1000) begin n_bad++; $display("FAIL rr_valid_last got %b want 1000", valid); end
    n_cmp++; if (data !== 64'h1FF8_1FF8_0000_1FF8) begin n_bad++; $display("FAIL rr_data got %h want 1ff81ff800001ff8", data); end
  endtask

  task automatic test_ops;
    logic [15:0] e7, e3;
`ifdef GLYPH_FETCH_OPS_EN
    e7 = 16'h1FF8;
    e3 = 16'h0180;
`else
    e7 = 16'h0000;
    e3 = 16'h0000;
`endif
    code[3:0] = 4'd10;
    row[3:0] = 4'd7;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    n_cmp++; if (valid !== 4'b0001) begin n_bad++; $display("FAIL op_valid got %b want 0001", valid); end
    n_cmp++; if (data[15:0] !== e7) begin n_bad++; $display("FAIL op_plus_row7 got %h want %h", data[15:0], e7); end
    row[3:0] = 4'd3;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    n_cmp++; if (data[15:0] !== e3) begin n_bad++; $display("FAIL op_plus_row3 got %h want %h", data[15:0], e3); end
  endtask

  localparam logic [3:0] HR [3] = '{4'd11, 4'd12, 4'd13};
  localparam logic [15:0] HD [3] = '{16'h181F, 16'h0000, 16'h0000};

  task automatic test_row_range;
    for (int i = 0; i < 3; i++) begin
      code12[3:0] = (i == 2) ? 4'd8 : 4'd0;
      row12[3:0] = HR[i];
      req12 = 4'b0001;
      tick();
      req12 = 4'b0000;
      tick();
      n_cmp++; if (valid12 !== 4'b0001) begin n_bad++; $display("FAIL range_valid[%0d] got %b want 0001", i, valid12); end
      n_cmp++; if (data12[15:0] !== HD[i]) begin n_bad++; $display("FAIL range_data[%0d] row %0d got %h want %h", i, HR[i], data12[15:0], HD[i]); end
    end
  endtask

  task automatic test_reset_inflight;
    do_reset();
    code[7:0] = {4'd8, 4'd9};
    row[7:0] = {4'd3, 4'd0};
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL inflight_ack1 got %b want 0010", ack); end
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL inflight_ack0 got %b want 0001", ack); end
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL async_ack got %b want 0000", ack); end
    n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL async_valid got %b want 0000", valid); end
    n_cmp++; if (data !== 64'h0) begin n_bad++; $display("FAIL async_data got %h want 0", data); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (valid !== 4'b0000) begin n_bad++; $display("FAIL post_reset_valid[%0d] got %b want 0000", i, valid); end
    end
    n_cmp++; if (data !== 64'h0) begin n_bad++; $display("FAIL post_reset_data got %h want 0", data); end
    req = 4'b0011;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL post_reset_grant got %b want 0001", ack); end
    req = 4'b0000;
    tick();
    n_cmp++; if (data[15:0] !== 16'h1FF8) begin n_bad++; $display("FAIL post_reset_data0 got %h want 1ff8", data[15:0]); end
  endtask

  task automatic test_pointer;
    do_reset();
    code[11:4] = {4'd9, 4'd8};
    row[11:4] = {4'd6, 4'd3};
    req = 4'b0010;
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL ptr_ack1 got %b want 0010", ack); end
    req = 4'b0000;
    tick();
    n_cmp++; if (data[31:16] !== 16'h181F) begin n_bad++; $display("FAIL ptr_data1 got %h want 181f", data[31:16]); end
    req = 4'b0100;
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL ptr_ack2 got %b want 0100", ack); end
    req = 4'b0000;
    tick();
    n_cmp++; if (valid !== 4'b0100) begin n_bad++; $display("FAIL ptr_valid2 got %b want 0100", valid); end
    n_cmp++; if (data[47:32] !== 16'h1FFF) begin n_bad++; $display("FAIL ptr_data2 got %h want 1fff", data[47:32]); end
    n_cmp++; if (data[31:16] !== 16'h181F) begin n_bad++; $display("FAIL ptr_data1_hold got %h want 181f", data[31:16]); end
    req = 4'b0011;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL ptr_wrap got %b want 0001", ack); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_digits();
    test_round_robin();
    test_ops();
    test_row_range();
    test_reset_inflight();
    test_pointer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
